cache_lru_repl: RTL and testbench

Parametrised true-LRU replacement engine for the set-associative L1 caches. It holds a per-set age permutation over `WAYS` ways and updates it on every hit or fill touch. On a miss it returns a registered one-hot victim, preferring the lowest invalid way and otherwise the least-recently-used way. It sits beside the tag/data arrays and is driven by the cache main FSM: touch on hit/refill, victim query on the miss path.

---
 rtl/cache_lru_repl.sv | 124 ++++++++++++
 tb/tb_cache_lru_repl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_lru_repl.sv
// True-LRU replacement engine: per-set age permutation, touch on hit/fill,
// registered one-hot victim (lowest invalid way first, else the LRU way).
module cache_lru_repl #(
  parameter int WAYS      = 4,
  parameter int SETS      = 64,
  parameter int INDEX_LSB = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            touch_en,
  input  logic [31:0]     touch_addr,
  input  logic [WAYS-1:0] touch_way,
  input  logic            victim_req,
  input  logic [31:0]     victim_addr,
  input  logic [WAYS-1:0] way_valid,
  output logic            victim_vld,
  output logic [WAYS-1:0] victim_way,
  output logic            init_busy
);

  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int IW = $clog2(SETS);
  localparam logic [WAYS-1:0] ONE_W = WAYS'(1);

  typedef enum logic {S_INIT, S_READY} state_t;
  typedef logic [WAYS-1:0][AW-1:0] ages_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            victim_vld_q, victim_vld_d;
  logic [WAYS-1:0] victim_way_q, victim_way_d;

  // NOTE: the age array has no reset; the INIT sweep loads every set, which
  // keeps it a plain memory instead of thousands of resettable flops.
  ages_t age_mem [SETS];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      victim_vld_q <= 1'b0;
      victim_way_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      victim_vld_q <= victim_vld_d;
      victim_way_q <= victim_way_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + IW'(1);
        if (cnt_q == IW'(SETS - 1)) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  assign init_busy = (state_q == S_INIT);

  logic [IW-1:0] t_idx, v_idx;
  logic          addr_unused;
  assign t_idx       = touch_addr[INDEX_LSB +: IW];
  assign v_idx       = victim_addr[INDEX_LSB +: IW];
  assign addr_unused = ^{touch_addr, victim_addr};

  logic    touch_onehot, touch_fire;
  ages_t   t_ages, new_ages, ident;
  logic [AW-1:0] t_age;

  assign touch_onehot = (touch_way != '0) && ((touch_way & (touch_way - ONE_W)) == '0);
  assign touch_fire   = touch_en && !init_busy && touch_onehot;

  always_comb begin
    t_ages   = age_mem[t_idx];
    t_age    = '0;
    new_ages = '0;
    ident    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (touch_way[w]) t_age = t_ages[w];
      ident[w] = AW'(w);
    end
    // Ways younger than the touched one age by one; the touched way becomes MRU.
    for (int w = 0; w < WAYS; w++) begin
      if (touch_way[w])             new_ages[w] = '0;
      else if (t_ages[w] < t_age)   new_ages[w] = t_ages[w] + AW'(1);
      else                          new_ages[w] = t_ages[w];
    end
  end

  always_ff @(posedge clk) begin
    if (init_busy)       age_mem[cnt_q] <= ident;
    else if (touch_fire) age_mem[t_idx] <= new_ages;
  end

  ages_t           q_ages;
  logic [WAYS-1:0] invalid, inv_pick, lru_pick;

  always_comb begin
    // Same-index touch in this cycle is bypassed so the query sees post-touch ages.
    q_ages   = (touch_fire && (t_idx == v_idx)) ? new_ages : age_mem[v_idx];
    invalid  = ~way_valid;
    inv_pick = invalid & (~invalid + ONE_W);
    lru_pick = '0;
    for (int w = 0; w < WAYS; w++) begin
      lru_pick[w] = (q_ages[w] == AW'(WAYS - 1));
    end
    victim_vld_d = victim_req && !init_busy;
    victim_way_d = victim_way_q;
    if (victim_vld_d) victim_way_d = (|invalid) ? inv_pick : lru_pick;
  end

  assign victim_vld = victim_vld_q;
  assign victim_way = victim_way_q;

endmodule

// File: tb/tb_cache_lru_repl.sv
// Bench for cache_lru_repl: directed checks on a 4-way/64-set instance and a
// random stream on an 8-way/16-set instance, both against a recency-list model.
module tb_cache_lru_repl;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        a_touch_en, a_victim_req, a_victim_vld, a_init_busy;
  logic [31:0] a_touch_addr, a_victim_addr;
  logic [3:0]  a_touch_way, a_way_valid, a_victim_way;

  logic        b_touch_en, b_victim_req, b_victim_vld, b_init_busy;
  logic [31:0] b_touch_addr, b_victim_addr;
  logic [7:0]  b_touch_way, b_way_valid, b_victim_way;

  cache_lru_repl #(.WAYS(4), .SETS(64), .INDEX_LSB(6)) dut_a (
    .clk(clk), .rstn(rstn),
    .touch_en(a_touch_en), .touch_addr(a_touch_addr), .touch_way(a_touch_way),
    .victim_req(a_victim_req), .victim_addr(a_victim_addr), .way_valid(a_way_valid),
    .victim_vld(a_victim_vld), .victim_way(a_victim_way), .init_busy(a_init_busy)
  );

  cache_lru_repl #(.WAYS(8), .SETS(16), .INDEX_LSB(6)) dut_b (
    .clk(clk), .rstn(rstn),
    .touch_en(b_touch_en), .touch_addr(b_touch_addr), .touch_way(b_touch_way),
    .victim_req(b_victim_req), .victim_addr(b_victim_addr), .way_valid(b_way_valid),
    .victim_vld(b_victim_vld), .victim_way(b_victim_way), .init_busy(b_init_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: per set, a recency list of way numbers, MRU at the front.
  int         ord [2][64][$];
  int         cyc [2];
  bit         exp_vld [2];
  logic [7:0] exp_way [2];

  function automatic int ways_of(int d); return (d == 0) ? 4 : 8; endfunction
  function automatic int sets_of(int d); return (d == 0) ? 64 : 16; endfunction

  function automatic int set_of(int d, logic [31:0] addr);
    return int'((addr >> 6) & (sets_of(d) - 1));
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; exp_vld[d] = 1'b0; exp_way[d] = '0;
      for (int s = 0; s < 64; s++) begin
        ord[d][s].delete();
        for (int w = 0; w < ways_of(d); w++) ord[d][s].push_back(w);
      end
    end
  endfunction

  function automatic void m_touch(int d, int s, logic [7:0] way);
    int t;
    t = -1;
    if ($countones(way) != 1) return;
    for (int w = 0; w < 8; w++) if (way[w]) t = w;
    if (t >= ways_of(d)) return;
    for (int i = 0; i < ord[d][s].size(); i++) begin
      if (ord[d][s][i] == t) begin ord[d][s].delete(i); break; end
    end
    ord[d][s].push_front(t);
  endfunction

  function automatic logic [7:0] m_victim(int d, int s, logic [7:0] valid);
    logic [7:0] one;
    one = 8'd1;
    for (int w = 0; w < ways_of(d); w++) if (!valid[w]) return one << w;
    return one << ord[d][s][ways_of(d) - 1];
  endfunction

  // Advance the model across one rising edge; a touch in the same cycle is
  // applied before the query is answered.
  function automatic void model_cycle(int d, logic ten, logic [31:0] taddr, logic [7:0] tway,
                                      logic vreq, logic [31:0] vaddr, logic [7:0] valid);
    bit busy;
    busy = cyc[d] < sets_of(d);
    if (!busy && ten) m_touch(d, set_of(d, taddr), tway);
    exp_vld[d] = vreq && !busy;
    if (exp_vld[d]) exp_way[d] = m_victim(d, set_of(d, vaddr), valid);
    cyc[d]++;
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic idle();
    a_touch_en = 0; a_touch_addr = '0; a_touch_way = '0;
    a_victim_req = 0; a_victim_addr = '0; a_way_valid = 4'hF;
    b_touch_en = 0; b_touch_addr = '0; b_touch_way = '0;
    b_victim_req = 0; b_victim_addr = '0; b_way_valid = 8'hFF;
  endtask

  function automatic logic [31:0] a_addr(int s);
    return ($urandom() & ~32'h0000_0FC0) | (32'(s) << 6);
  endfunction

  task automatic a_touch(int s, logic [3:0] w);
    a_touch_en = 1; a_touch_addr = a_addr(s); a_touch_way = w;
  endtask

  task automatic a_query(int s, logic [3:0] v);
    a_victim_req = 1; a_victim_addr = a_addr(s); a_way_valid = v;
  endtask

  task automatic step(string tag);
    model_cycle(0, a_touch_en, a_touch_addr, {4'h0, a_touch_way},
                a_victim_req, a_victim_addr, {4'hF, a_way_valid});
    model_cycle(1, b_touch_en, b_touch_addr, b_touch_way,
                b_victim_req, b_victim_addr, b_way_valid);
    @(posedge clk);
    #1;
    check({tag, ".a_vld"},  a_victim_vld, exp_vld[0]);
    check({tag, ".a_way"},  a_victim_way, exp_way[0]);
    check({tag, ".a_busy"}, a_init_busy,  cyc[0] < 64);
    check({tag, ".b_vld"},  b_victim_vld, exp_vld[1]);
    check({tag, ".b_way"},  b_victim_way, exp_way[1]);
    check({tag, ".b_busy"}, b_init_busy,  cyc[1] < 16);
  endtask

  // Called between edges: outputs must clear while rstn is low, without a clock.
  task automatic do_reset(string tag);
    rstn = 0;
    idle();
    #1;
    check({tag, ".a_vld"},  a_victim_vld, 0);
    check({tag, ".a_way"},  a_victim_way, 0);
    check({tag, ".a_busy"}, a_init_busy,  1);
    check({tag, ".b_vld"},  b_victim_vld, 0);
    check({tag, ".b_busy"}, b_init_busy,  1);
    m_reset();
    #1;
    rstn = 1;
  endtask

  // 64 init edges; queries and touches issued meanwhile must be dropped.
  task automatic run_init();
    for (int k = 0; k < 64; k++) begin
      idle();
      if (k % 5 == 0 || k == 63) a_query($urandom_range(0, 63), 4'hF);
      if (k % 7 == 0) a_touch(5, 4'b1000);
      step("init");
    end
  endtask

  logic [7:0] seen;
  int         r;

  initial begin
    rstn = 0;
    idle();
    #2;
    do_reset("por");
    run_init();

    idle(); a_query(5, 4'hF); step("q_set5");
    check("init_lru", a_victim_way, 4'b1000);

    idle(); a_touch(3, 4'b1000); step("t3");
    idle(); a_touch(3, 4'b0100); step("t2");
    idle(); a_touch(3, 4'b0010); step("t1");
    idle(); a_touch(3, 4'b0001); step("t0");
    idle(); a_query(3, 4'hF); step("lru_a");
    check("lru_order", a_victim_way, 4'b1000);
    idle(); a_touch(3, 4'b1000); step("t3b");
    idle(); a_query(3, 4'hF); step("lru_b");
    check("lru_after_touch3", a_victim_way, 4'b0100);

    idle(); a_touch(9, 4'b0010); step("s9t1");
    idle(); a_touch(9, 4'b0100); step("s9t2");
    idle(); a_touch(9, 4'b1000); step("s9t3");
    idle(); a_query(9, 4'b1010); step("inv_a");
    check("inv_1010", a_victim_way, 4'b0001);
    idle(); a_query(9, 4'b1011); step("inv_b");
    check("inv_1011", a_victim_way, 4'b0100);
    idle(); a_query(9, 4'b1111); step("inv_c");

    idle(); a_touch(7, 4'b1000); a_query(7, 4'hF); step("bypass");
    check("bypass_way", a_victim_way, 4'b0100);
    idle(); a_touch(8, 4'b1000); a_query(10, 4'hF); step("diff_idx");

    idle(); a_touch(11, 4'b0110); step("illegal");
    idle(); a_touch(11, 4'b0000); step("zero_way");
    idle(); a_query(11, 4'hF); step("illegal_q");
    check("illegal_unchanged", a_victim_way, 4'b1000);
    idle(); a_touch(12, 4'b0001); step("mru_touch");
    idle(); a_query(12, 4'hF); step("mru_q");

    idle(); a_query(3, 4'hF); step("b2b_0");
    idle(); a_query(9, 4'hF); step("b2b_1");
    idle(); step("hold");

    idle(); a_query(3, 4'hF); step("pre_rst");
    check("pre_rst_vld", a_victim_vld, 1);
    do_reset("mid");
    run_init();
    idle(); a_query(3, 4'hF); step("post_rst");
    check("post_rst_lru", a_victim_way, 4'b1000);

    for (int i = 0; i < 1500; i++) begin
      idle();
      b_touch_en   = ($urandom_range(0, 3) != 0);
      b_touch_addr = $urandom();
      r            = $urandom_range(0, 9);
      b_touch_way  = (r < 8) ? (8'd1 << r) : 8'($urandom());
      b_victim_req = $urandom_range(0, 1);
      b_victim_addr = ($urandom_range(0, 3) == 0) ? b_touch_addr : $urandom();
      b_way_valid  = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'hFF;
      step("rnd");
    end

    // Repeatedly promoting the LRU way must visit every way once per set.
    for (int s = 0; s < 16; s++) begin
      seen = '0;
      for (int k = 0; k < 8; k++) begin
        idle(); b_victim_req = 1; b_victim_addr = 32'(s) << 6; step("perm_q");
        seen |= b_victim_way;
        idle(); b_touch_en = 1; b_touch_addr = 32'(s) << 6; b_touch_way = exp_way[1];
        step("perm_t");
      end
      check("perm_cover", seen, 8'hFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
